// File: rtl/fp_counter_pkg.sv
// rtl/fp_counter_pkg.sv - shared widths, increment builder and sample encoder for fp_counter_bank
package fp_counter_pkg;

    // Widest counter the helper functions handle; parameters are zero-extended to this.
    localparam int MAX_W = 64;

    // Number of raw low bits below the exponent field.
    function automatic int lsb_width(input int cnt_w, input int out_e);
        return cnt_w - (1 << out_e);
    endfunction

    // Width of the encoded {sign, exponent, mantissa} sample.
    function automatic int out_width(input int out_e, input int out_m);
        return 1 + out_e + out_m;
    endfunction

    // Hidden-one mantissa shifted left by the exponent, zero-extended.
    function automatic logic [MAX_W-1:0] build_inc(input logic [MAX_W-1:0] man,
                                                   input int unsigned  exp_v,
                                                   input int unsigned  man_w);
        logic [MAX_W-1:0] base;
        base = (MAX_W'(1) << man_w) | man;
        return base << exp_v;
    endfunction

    // Order-preserving compression of a two's complement counter. Negative values
    // use the one's complement magnitude for the exponent, then invert the exponent
    // so the code sorts correctly as a signed byte; the mantissa comes from raw c.
    function automatic logic [31:0] encode(input logic [MAX_W-1:0] c,
                                           input int cnt_w,
                                           input int out_e,
                                           input int out_m);
        int               lsb_w;
        int               e;
        int               q;
        logic             s;
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] sh;
        logic [31:0]      e_v;
        logic [31:0]      e_mask;
        logic [31:0]      man;
        lsb_w  = cnt_w - (1 << out_e);
        s      = c[cnt_w-1];
        m      = s ? ~c : c;
        e      = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i >= lsb_w && i <= cnt_w - 2 && m[i]) begin
                e = i - lsb_w + 1;
            end
        end
        q      = (e == 0) ? lsb_w - 1 : lsb_w + e - 2;
        sh     = c >> (q - out_m + 1);
        man    = sh[31:0] & ((32'd1 << out_m) - 32'd1);
        e_mask = (32'd1 << out_e) - 32'd1;
        e_v    = 32'(e);
        e_v    = s ? (~e_v & e_mask) : e_v;
        return (32'(s) << (out_e + out_m)) | (e_v << out_m) | man;
    endfunction

endpackage

// File: rtl/fp_counter_bank_if.sv
// rtl/fp_counter_bank_if.sv - encoded sample stream between the counter bank and its consumer
interface fp_counter_bank_if
    import fp_counter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int OUT_E    = 4,
    parameter int OUT_M    = 3
);
    localparam int CHAN_W = $clog2(CHANNELS);
    localparam int VAL_W  = out_width(OUT_E, OUT_M);

    logic              out_valid;
    logic              out_ready;
    logic [CHAN_W-1:0] out_chan;
    logic [VAL_W-1:0]  out_value;

    modport master (
        output out_valid,
        output out_chan,
        output out_value,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_chan,
        input  out_value,
        output out_ready
    );
endinterface

// File: rtl/fp_counter_bank_encode.sv
// rtl/fp_counter_bank_encode.sv - combinational counter-to-sample encoder
module fp_encode
    import fp_counter_pkg::*;
#(
    parameter int CNT_W = 30,
    parameter int OUT_E = 4,
    parameter int OUT_M = 3
) (
    input  logic [CNT_W-1:0]                 cnt_i,
    output logic [out_width(OUT_E, OUT_M)-1:0] code_o
);
    localparam int VAL_W = out_width(OUT_E, OUT_M);

    // Encode the selected counter into the sign/exponent/mantissa sample.
    always_comb begin
        code_o = VAL_W'(encode(MAX_W'(cnt_i), CNT_W, OUT_E, OUT_M));
    end
endmodule

// File: rtl/fp_counter_bank.sv
// rtl/fp_counter_bank.sv - multi-channel pseudo-float step accumulators with round-robin encoded stream
module fp_counter_bank
    import fp_counter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 30,
    parameter int STEP_M   = 4,
    parameter int STEP_E   = 4,
    parameter int OUT_E    = 4,
    parameter int OUT_M    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [STEP_E-1:0]   step_exp_i,
    input  logic [STEP_M-1:0]   step_man_i,
    input  logic                step_dn_i,
    input  logic                saturate_i,
    input  logic [CHANNELS-1:0] step_en_i,
    input  logic [CHANNELS-1:0] clr_i,
    output logic [CHANNELS-1:0] ovf_o,
    fp_counter_bank_if.master   out_if
);
    localparam int LSB_W = lsb_width(CNT_W, OUT_E);
    localparam int PTR_W = $clog2(CHANNELS);
    localparam int VAL_W = out_width(OUT_E, OUT_M);

    localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    if (LSB_W < OUT_M || STEP_M + (1 << STEP_E) > CNT_W - 1) begin : g_param_check
        $error("fp_counter_bank: illegal parameter combination");
    end

    logic [CNT_W-1:0] inc;
    logic [CNT_W-1:0] cnt_all [CHANNELS];

    // Shared increment; fits in CNT_W-1 bits so it is always positive.
    always_comb begin
        inc = CNT_W'(build_inc(MAX_W'(step_man_i), int'(step_exp_i), STEP_M));
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             ovf_q, ovf_d;
        logic [CNT_W:0]   sum;
        logic             sum_ovf;

        // Next count: clear beats step; overflow is detected in one extra sign bit.
        always_comb begin
            sum     = step_dn_i ? ({cnt_q[CNT_W-1], cnt_q} - {1'b0, inc})
                                : ({cnt_q[CNT_W-1], cnt_q} + {1'b0, inc});
            sum_ovf = sum[CNT_W] ^ sum[CNT_W-1];
            cnt_d   = cnt_q;
            ovf_d   = ovf_q;
            if (clr_i[i]) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (step_en_i[i]) begin
                cnt_d = sum[CNT_W-1:0];
                if (sum_ovf) begin
                    ovf_d = 1'b1;
                    if (saturate_i) begin
                        cnt_d = step_dn_i ? CNT_MIN : CNT_MAX;
                    end
                end
            end
        end

        // Counter and sticky overflow registers.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        assign cnt_all[i] = cnt_q;
        assign ovf_o[i]   = ovf_q;
    end

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] chan_q, chan_d;
    logic             valid_q, valid_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic [CNT_W-1:0] cnt_sel;
    logic [VAL_W-1:0] enc;

    assign cnt_sel = cnt_all[ptr_q];

    fp_encode #(
        .CNT_W (CNT_W),
        .OUT_E (OUT_E),
        .OUT_M (OUT_M)
    ) u_encode (
        .cnt_i  (cnt_sel),
        .code_o (enc)
    );

    // Refill the output register whenever it is empty or being taken, then advance the pointer.
    always_comb begin
        ptr_d   = ptr_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        value_d = value_q;
        if (!valid_q || out_if.out_ready) begin
            valid_d = 1'b1;
            chan_d  = ptr_q;
            value_d = enc;
            ptr_d   = (ptr_q == PTR_W'(CHANNELS - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // Scheduler pointer and output sample register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            value_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            value_q <= value_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_chan  = chan_q;
    assign out_if.out_value = value_q;
endmodule
